// File: rtl/cntr_arbiter_if.sv
// Purpose: request/issue bundle between counter requesters and cntr_arbiter.
// Ports (signals):
//   req_cntr   - packed 10-bit counter values, channel i at [10i+9:10i]
//   req_valid  - per-channel one-cycle capture strobe
//   ovf_clr    - synchronous clear of the sticky overflow flags
//   cntr       - issued counter value
//   cntr_valid - one-cycle strobe qualifying cntr/cntr_ch
//   cntr_ch    - channel index of the issued value
//   pending    - per-channel holding-slot occupied flags
//   ovf        - per-channel sticky overflow flags
// Modports: master = requester side, slave = arbiter side.
interface cntr_arbiter_if #(
  parameter int unsigned N_CH = 4
) ();
  logic [10*N_CH-1:0] req_cntr;
  logic [N_CH-1:0]    req_valid;
  logic               ovf_clr;
  logic [9:0]         cntr;
  logic               cntr_valid;
  logic [2:0]         cntr_ch;
  logic [N_CH-1:0]    pending;
  logic [N_CH-1:0]    ovf;

  modport master (
    output req_cntr, req_valid, ovf_clr,
    input  cntr, cntr_valid, cntr_ch, pending, ovf
  );

  modport slave (
    input  req_cntr, req_valid, ovf_clr,
    output cntr, cntr_valid, cntr_ch, pending, ovf
  );
endinterface

// File: rtl/cntr_arbiter.sv
// Purpose: round-robin arbiter that collects 10-bit counter values from
//   N_CH requesters into per-channel holding slots and issues them one at a
//   time to a downstream datapath, with at least GAP idle cycles between
//   consecutive issue pulses. A new value arriving while a channel's slot is
//   still occupied is dropped and flagged in a sticky overflow bit.
// Ports:
//   clk - single clock, all state on the rising edge
//   rst - asynchronous active-high reset
//   bus - cntr_arbiter_if slave modport (requests in, issued value out)
// Parameters:
//   N_CH - number of requester channels (2..8)
//   GAP  - minimum idle cycles between issue pulses (0..15)
module cntr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned GAP  = 2
) (
  input  logic          clk,
  input  logic          rst,
  cntr_arbiter_if.slave bus
);

  localparam int unsigned CW     = 10;
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned HOLD_W = 4;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLDOFF
  } state_e;

  state_e                  state_q;
  logic [CH_W-1:0]         grant_q;     // last granted channel; current grant while in ISSUE
  logic [HOLD_W-1:0]       hold_cnt_q;
  logic [CW-1:0]           cntr_q;
  logic                    cntr_valid_q;
  logic [2:0]              cntr_ch_q;
  logic [N_CH-1:0][CW-1:0] slot_q;
  logic [N_CH-1:0][CW-1:0] slot_d;
  logic [N_CH-1:0]         pending_q;
  logic [N_CH-1:0]         pending_d;
  logic [N_CH-1:0]         ovf_q;
  logic [N_CH-1:0]         ovf_d;

  logic [N_CH-1:0][CW-1:0] req_arr_c;
  logic                    issuing_c;
  logic                    found_c;
  logic [CH_W-1:0]         pick_c;

  assign req_arr_c = bus.req_cntr;

  // Round-robin search: first pending channel after the last grant, wrapping.
  always_comb begin
    found_c = 1'b0;
    pick_c  = grant_q;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      if (!found_c && pending_q[CH_W'((32'(grant_q) + k) % N_CH)]) begin
        found_c = 1'b1;
        pick_c  = CH_W'((32'(grant_q) + k) % N_CH);
      end
    end
  end

  // Slot capture, pending bookkeeping and overflow detection.
  // The channel being issued frees its slot at the end of ISSUE, so a
  // same-cycle request on that channel refills the slot instead of overflowing.
  always_comb begin
    issuing_c = (state_q == ST_ISSUE);
    slot_d    = slot_q;
    pending_d = pending_q;
    ovf_d     = bus.ovf_clr ? '0 : ovf_q;
    if (issuing_c) begin
      pending_d[grant_q] = 1'b0;
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (bus.req_valid[CH_W'(i)]) begin
        if (!pending_q[CH_W'(i)] || (issuing_c && (grant_q == CH_W'(i)))) begin
          slot_d[CH_W'(i)]    = req_arr_c[CH_W'(i)];
          pending_d[CH_W'(i)] = 1'b1;
        end else begin
          ovf_d[CH_W'(i)] = 1'b1;
        end
      end
    end
  end

  // Issue FSM with registered outputs; cntr/cntr_ch hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= LAST_CH;
      hold_cnt_q   <= '0;
      cntr_q       <= '0;
      cntr_valid_q <= 1'b0;
      cntr_ch_q    <= '0;
      slot_q       <= '0;
      pending_q    <= '0;
      ovf_q        <= '0;
    end else begin
      slot_q       <= slot_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      cntr_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            state_q      <= ST_ISSUE;
            grant_q      <= pick_c;
            cntr_q       <= slot_q[pick_c];
            cntr_valid_q <= 1'b1;
            cntr_ch_q    <= 3'(pick_c);
          end
        end
        ST_ISSUE: begin
          if (GAP != 0) begin
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= HOLD_W'(GAP - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cntr       = cntr_q;
  assign bus.cntr_valid = cntr_valid_q;
  assign bus.cntr_ch    = cntr_ch_q;
  assign bus.pending    = pending_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_cntr_arbiter.sv
// Purpose: randomized + directed bench for cntr_arbiter. The reference model
//   tracks held values, pending/overflow flags and the earliest cycle at which
//   the next issue may be decided; each decided issue is queued with its
//   expected cycle, and a negedge monitor pops and compares DUT pulses.
module tb_cntr_arbiter;

  localparam int N_CH = 4;
  localparam int GAP  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cntr_arbiter_if #(.N_CH(N_CH)) bus ();

  cntr_arbiter #(.N_CH(N_CH), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
    int ch;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_held[N_CH];
  bit m_pend[N_CH];
  bit m_ovf[N_CH];
  int m_last;
  int m_next_ok;
  int m_issuing;
  int m_last_val;
  int m_last_ch;

  // Driven stimulus
  logic [N_CH-1:0] drv_rv;
  logic [9:0]      drv_val[N_CH];
  logic            drv_clr;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_held[i] = 0;
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
    m_last     = N_CH - 1;
    m_next_ok  = 0;
    m_issuing  = -1;
    m_last_val = 0;
    m_last_ch  = 0;
    sb.delete();
  endtask

  // One rising edge of the reference behaviour, using pre-edge state.
  task automatic model_step();
    int g;
    bit setv[N_CH];
    g = -1;
    if (cyc >= m_next_ok) begin
      for (int k = 1; k <= N_CH; k++) begin
        if (g < 0 && m_pend[(m_last + k) % N_CH]) g = (m_last + k) % N_CH;
      end
      if (g >= 0) begin
        sb.push_back('{cyc: cyc, val: m_held[g], ch: g});
        m_last     = g;
        m_next_ok  = cyc + GAP + 2;
        m_last_val = m_held[g];
        m_last_ch  = g;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      setv[i] = 1'b0;
      if (drv_rv[i]) begin
        if (!m_pend[i] || m_issuing == i) begin
          m_held[i] = int'(drv_val[i]);
          m_pend[i] = 1'b1;
        end else begin
          setv[i] = 1'b1;
        end
      end else if (m_issuing == i) begin
        m_pend[i] = 1'b0;
      end
    end
    for (int i = 0; i < N_CH; i++) m_ovf[i] = (drv_clr ? 1'b0 : m_ovf[i]) | setv[i];
    m_issuing = g;
  endtask

  task automatic apply();
    logic [N_CH-1:0][9:0] pk;
    for (int i = 0; i < N_CH; i++) pk[i] = drv_val[i];
    bus.req_valid = drv_rv;
    bus.req_cntr  = pk;
    bus.ovf_clr   = drv_clr;
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    cyc++;
    if (!rst) model_step();
    #2;
    drv_rv  = '0;
    drv_clr = 1'b0;
    for (int i = 0; i < N_CH; i++) drv_val[i] = 10'($urandom);
    apply();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_req(input int ch, input int val);
    drv_rv[ch]  = 1'b1;
    drv_val[ch] = 10'(val);
  endtask

  // Requests presented while rst is high must be ignored.
  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    repeat (n) begin
      drv_rv = N_CH'($urandom);
      tick();
    end
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t e;
    logic [N_CH-1:0] ep;
    logic [N_CH-1:0] eo;
    for (int i = 0; i < N_CH; i++) begin
      ep[i] = m_pend[i];
      eo[i] = m_ovf[i];
    end
    if (bus.cntr_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got cntr=%0d ch=%0d, required no pulse",
                 cyc, bus.cntr, bus.cntr_ch);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || bus.cntr !== 10'(e.val) || bus.cntr_ch !== 3'(e.ch)) begin
          errors++;
          $display("FAIL issue got cyc=%0d cntr=%0d ch=%0d, required cyc=%0d cntr=%0d ch=%0d",
                   cyc, bus.cntr, bus.cntr_ch, e.cyc, e.val, e.ch);
        end
      end
    end else begin
      checks++;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        errors++;
        $display("FAIL missing_pulse at cyc=%0d got cntr_valid=%b, required cntr=%0d ch=%0d",
                 cyc, bus.cntr_valid, e.val, e.ch);
      end
      checks++;
      if (bus.cntr !== 10'(m_last_val) || bus.cntr_ch !== 3'(m_last_ch)) begin
        errors++;
        $display("FAIL hold cyc=%0d got cntr=%0d ch=%0d, required cntr=%0d ch=%0d",
                 cyc, bus.cntr, bus.cntr_ch, m_last_val, m_last_ch);
      end
    end
    checks++;
    if (bus.pending !== ep) begin
      errors++;
      $display("FAIL pending cyc=%0d got %b, required %b", cyc, bus.pending, ep);
    end
    checks++;
    if (bus.ovf !== eo) begin
      errors++;
      $display("FAIL ovf cyc=%0d got %b, required %b", cyc, bus.ovf, eo);
    end
  end

  initial begin
    drv_rv  = '0;
    drv_clr = 1'b0;
    for (int i = 0; i < N_CH; i++) drv_val[i] = '0;
    apply();
    model_reset();
    do_reset(3);

    // Single request after reset
    set_req(0, 800);
    tick();
    idle(8);

    // Simultaneous requests on all channels
    set_req(0, 100); set_req(1, 200); set_req(2, 300); set_req(3, 400);
    tick();
    idle(20);

    // Wrap: last grant is ch3, then ch3 and ch0 pending together
    set_req(3, 11); set_req(0, 22);
    tick();
    idle(12);

    // Overflow while the FSM is in holdoff after issuing ch0
    set_req(0, 1); set_req(1, 5);
    tick(); tick(); tick();
    set_req(1, 6);
    tick();
    idle(10);
    drv_clr = 1'b1;
    tick();
    idle(3);

    // Same-cycle refill during ch2 issue
    set_req(2, 55);
    tick(); tick();
    set_req(2, 77);
    tick();
    idle(12);

    // ovf_clr together with a new overflow on the same channel
    set_req(1, 9); set_req(3, 1);
    tick();
    set_req(3, 2);
    tick();
    set_req(3, 3);
    drv_clr = 1'b1;
    tick();
    idle(15);

    // Reset during holdoff with ch1 still pending
    set_req(0, 1); set_req(1, 2);
    tick(); tick(); tick();
    do_reset(2);
    idle(10);

    // Randomized traffic with occasional clears and resets
    for (int t = 0; t < 2000; t++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(5) == 0) set_req(c, int'($urandom_range(1023)));
      end
      drv_clr = ($urandom_range(19) == 0);
      if ($urandom_range(399) == 0) do_reset(2);
      else tick();
    end

    // Drain with a bounded wait
    for (int k = 0; k < 200 && sb.size() > 0; k++) tick();
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding issues, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
